aes_byte_loader: RTL and testbench
==================================

Name: aes_byte_loader

Overview:
- Upstream feeder for the combinational AES encryption core.
- Accepts byte-serial plaintext and cipher-key bytes over a valid/ready stream.
- Assembles the bytes into the core's 128-bit block input and N-bit key input, and holds both stable behind a valid/ready handshake while the core consumes them.
- Retains the key, so one key load serves any number of subsequent blocks.

Parameters:
- N, 128, key width in bits (128/192/256); key length in bytes KB = N/8.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- s_data  input  8  incoming byte
- s_is_key  input  1  1 = byte belongs to key group, 0 = plaintext group
- s_valid  input  1  byte present
- s_ready  output  1  loader can accept a byte
- m_block  output  128  assembled plaintext to the encryption core
- m_key  output  N  retained key to the encryption core
- m_valid  output  1  m_block/m_key valid
- m_ready  input  1  core side has taken the block
- key_loaded  output  1  a complete key is held
- err  output  1  one-cycle error pulse

Behaviour:
- Reset: one clock; reset is asynchronous, active-low (rst_n). While rst_n=0, all of the following are 0:
  - m_block, m_key, m_valid, key_loaded, err
  - byte counter and group flag
  - s_ready is 0 during reset and 1 in the first cycle after release.
- A byte is accepted when s_valid & s_ready on a rising edge.
- Byte order: the first accepted byte of a group lands in the MSBs (block bits [127:120]; key bits [N-1:N-8]). Each later byte fills the next-lower byte lane.
- States:
  - COLLECT: s_ready=1, m_valid=0.
  - HOLD: s_ready=0, m_valid=1.
- Group handling in COLLECT:
  - The first byte of a group latches the group type from s_is_key.
  - The byte counter runs 0..15 for a plaintext group and 0..KB-1 for a key group.
- Type switch mid-group: if s_is_key differs from the latched type while count≠0:
  - err pulses in the next cycle.
  - The partial group is discarded; the staging register is not copied anywhere.
  - The offending byte starts a new group (count becomes 1).
- Key group completion: the last key byte is accepted at edge t.
  - m_key updates and key_loaded=1 from cycle t+1.
  - State stays COLLECT.
  - A partial key group never alters m_key.
- Plaintext group completion: the 16th byte is accepted at edge t.
  - If key_loaded=1: m_block updates and state goes to HOLD, so m_valid=1 from cycle t+1. Latency: last byte to m_valid is 1 cycle.
  - If key_loaded=0: the block is dropped, err pulses at t+1, and state stays COLLECT.
- HOLD:
  - m_block and m_key stay constant.
  - m_valid & m_ready at edge t returns the state to COLLECT, so s_ready=1 and m_valid=0 from t+1.
  - m_valid must not drop before m_ready.
- Key update while a block is held is impossible, because s_ready=0 in HOLD.
- Maximum throughput: one block per 17 cycles when m_ready is held 1.
- Counter wrap: the counter returns to 0 after the group's final byte. No overflow state exists.
- Reset mid-group or mid-HOLD: everything is discarded, key_loaded clears, and a key must be reloaded.
- s_data is ignored when s_valid=0 or s_ready=0.

Decomposition:
- Shared package aes_pkg:
  - AES_BLOCK_BYTES=16
  - state encoding COLLECT/HOLD
  - function keybytes(N)=N/8
- One natural sub-module, aes_byte_shifter (parameter W bits):
  - MSB-first byte shift register with load-enable and clear.
  - Instantiated once for the block staging register and once for the key staging register.

Test Plan:
- Load FIPS-197 key 000102030405060708090a0b0c0d0e0f, then plaintext 00112233445566778899aabbccddeeff, with m_ready=1:
  - m_block=00112233445566778899aabbccddeeff and m_key equal to the key.
  - m_valid is high exactly 1 cycle, starting 1 cycle after the 16th byte.
- Send plaintext bytes before any key:
  - err pulses once after the 16th byte.
  - m_valid stays 0 and key_loaded stays 0.
- With a key loaded, send 5 plaintext bytes then 1 key byte:
  - err pulses once.
  - Follow with 15 more key bytes: m_key equals the new 16-byte key. m_block is unchanged.
- Hold m_ready=0 for 10 cycles after a block completes:
  - m_valid stays 1, s_ready stays 0, and outputs are stable.
  - Raise m_ready: s_ready=1 the next cycle.
- Assert rst_n=0 mid-plaintext (after 8 bytes) and release:
  - All outputs are 0 and key_loaded=0.
  - A subsequent complete block yields err, not m_valid.
- N=256:
  - 32 key bytes 00..1f give m_key=000102…1f; key_loaded rises only after byte 32.
  - Two back-to-back plaintext blocks both emit with that same key.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the AES byte loader slice.
//   AES_BLOCK_BYTES : bytes in one AES plaintext block
//   state_t         : loader FSM encoding (COLLECT / HOLD)
//   keybytes(n)     : key length in bytes for an n-bit key
package aes_pkg;

   localparam int AES_BLOCK_BYTES = 16;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   function automatic int keybytes(input int n);
      return n / 8;
   endfunction

endpackage

// File: rtl/aes_byte_shifter.sv
// MSB-first byte shift register used as a staging buffer.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clr      : discard current contents
//   i_load     : shift i_byte in at the LSB end (older bytes move toward MSB)
//   i_byte     : incoming byte
//   o_q        : staged contents
// Clear and load in the same cycle leaves only the new byte, so an
// interrupting byte can start a fresh group without a bubble.
module aes_byte_shifter #(
   parameter int W = 128
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_clr,
   input  logic         i_load,
   input  logic [7:0]   i_byte,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;
   logic [W-1:0] w_base;

   assign w_base = i_clr ? '0 : r_q;
   assign o_q    = r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= {w_base[W-9:0], i_byte};
      end else if (i_clr) begin
         r_q <= '0;
      end
   end

endmodule

// File: rtl/aes_byte_loader.sv
// Byte-serial feeder for a combinational AES encryption core.
// Collects plaintext and key bytes from a valid/ready byte stream, keeps
// the last complete key, and presents each complete block with that key
// behind a valid/ready handshake.
//   clk, rst_n        : clock, asynchronous active-low reset
//   s_data/s_is_key   : incoming byte and its group (1 = key, 0 = plaintext)
//   s_valid/s_ready   : byte stream handshake
//   m_block/m_key     : block and retained key to the core
//   m_valid/m_ready   : core-side handshake
//   key_loaded        : a complete key is held
//   err               : one-cycle pulse on a broken group or a block with no key
module aes_byte_loader
   import aes_pkg::*;
#(
   parameter int N = 128
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [7:0]   s_data,
   input  logic         s_is_key,
   input  logic         s_valid,
   output logic         s_ready,
   output logic [127:0] m_block,
   output logic [N-1:0] m_key,
   output logic         m_valid,
   input  logic         m_ready,
   output logic         key_loaded,
   output logic         err
);

   localparam int KB = keybytes(N);
   localparam int CW = $clog2(KB);

   state_t          r_state;
   logic [CW-1:0]   r_cnt;
   logic            r_is_key;

   logic            w_accept;
   logic            w_switch;
   logic [CW-1:0]   w_pos;
   logic            w_last;
   logic [127:0]    w_blk_q;
   logic [N-1:0]    w_key_q;

   assign w_accept = s_valid & s_ready;
   // A group type change mid-group restarts counting at the offending byte.
   assign w_switch = (r_cnt != '0) && (s_is_key != r_is_key);
   assign w_pos    = w_switch ? '0 : r_cnt;
   assign w_last   = s_is_key ? (w_pos == CW'(KB - 1))
                              : (w_pos == CW'(AES_BLOCK_BYTES - 1));

   aes_byte_shifter #(.W(128)) u_blk_shift (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_accept & w_switch),
      .i_load (w_accept & ~s_is_key),
      .i_byte (s_data),
      .o_q    (w_blk_q)
   );

   aes_byte_shifter #(.W(N)) u_key_shift (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_accept & w_switch),
      .i_load (w_accept & s_is_key),
      .i_byte (s_data),
      .o_q    (w_key_q)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= COLLECT;
         r_cnt      <= '0;
         r_is_key   <= 1'b0;
         s_ready    <= 1'b0;
         m_valid    <= 1'b0;
         m_block    <= '0;
         m_key      <= '0;
         key_loaded <= 1'b0;
         err        <= 1'b0;
      end else begin
         err <= 1'b0;
         case (r_state)
            COLLECT: begin
               s_ready <= 1'b1;
               m_valid <= 1'b0;
               if (w_accept) begin
                  r_is_key <= s_is_key;
                  r_cnt    <= w_last ? '0 : w_pos + CW'(1);
                  if (w_switch) err <= 1'b1;
                  if (w_last) begin
                     // Final byte is taken straight from the stream so the
                     // outputs update on the same edge as the staging register.
                     if (s_is_key) begin
                        m_key      <= {w_key_q[N-9:0], s_data};
                        key_loaded <= 1'b1;
                     end else if (key_loaded) begin
                        m_block <= {w_blk_q[119:0], s_data};
                        r_state <= HOLD;
                        m_valid <= 1'b1;
                        s_ready <= 1'b0;
                     end else begin
                        err <= 1'b1;
                     end
                  end
               end
            end
            HOLD: begin
               if (m_ready) begin
                  r_state <= COLLECT;
                  m_valid <= 1'b0;
                  s_ready <= 1'b1;
               end
            end
            default: r_state <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_byte_loader.sv
module tb_aes_byte_loader;

   logic         clk = 1'b0;
   logic         rst_n;

   logic [7:0]   s_data;
   logic         s_is_key, s_valid, s_ready;
   logic [127:0] m_block;
   logic [127:0] m_key;
   logic         m_valid, m_ready, key_loaded, err;

   logic [7:0]   s2_data;
   logic         s2_is_key, s2_valid, s2_ready;
   logic [127:0] m2_block;
   logic [255:0] m2_key;
   logic         m2_valid, m2_ready, kl2, err2;

   int nchecks = 0;
   int nerrs   = 0;

   always #5 clk = ~clk;

   aes_byte_loader #(.N(128)) u_dut (
      .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_is_key(s_is_key),
      .s_valid(s_valid), .s_ready(s_ready), .m_block(m_block), .m_key(m_key),
      .m_valid(m_valid), .m_ready(m_ready), .key_loaded(key_loaded), .err(err)
   );

   aes_byte_loader #(.N(256)) u_dut256 (
      .clk(clk), .rst_n(rst_n), .s_data(s2_data), .s_is_key(s2_is_key),
      .s_valid(s2_valid), .s_ready(s2_ready), .m_block(m2_block), .m_key(m2_key),
      .m_valid(m2_valid), .m_ready(m2_ready), .key_loaded(kl2), .err(err2)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerrs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic k, input bit sel);
      if (!sel) begin
         chk("s_ready_before_byte", {255'd0, s_ready}, 256'd1);
         s_data = b; s_is_key = k; s_valid = 1'b1;
      end else begin
         chk("s2_ready_before_byte", {255'd0, s2_ready}, 256'd1);
         s2_data = b; s2_is_key = k; s2_valid = 1'b1;
      end
      @(posedge clk); #1;
      s_valid = 1'b0; s2_valid = 1'b0;
   endtask

   // Sends bytes first..first+cnt-1 of a left-aligned 256-bit vector.
   task automatic send_bytes(input logic [255:0] v, input int first, input int cnt,
                             input logic k, input bit sel);
      for (int i = first; i < first + cnt; i++) send(v[255-8*i -: 8], k, sel);
   endtask

   logic [127:0] key1, key2, pt1, pt2, pt3;
   logic [255:0] key256;

   initial begin
      key1   = 128'h000102030405060708090a0b0c0d0e0f;
      key2   = 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf;
      pt1    = 128'h00112233445566778899aabbccddeeff;
      pt2    = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
      pt3    = 128'hffeeddccbbaa99887766554433221100;
      key256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

      rst_n = 1'b0;
      s_data = '0; s_is_key = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
      s2_data = '0; s2_is_key = 1'b0; s2_valid = 1'b0; m2_ready = 1'b1;

      // Reset state
      #12;
      chk("rst_s_ready", {255'd0, s_ready}, 256'd0);
      chk("rst_m_valid", {255'd0, m_valid}, 256'd0);
      chk("rst_key_loaded", {255'd0, key_loaded}, 256'd0);
      chk("rst_err", {255'd0, err}, 256'd0);
      chk("rst_m_block", {128'd0, m_block}, 256'd0);
      chk("rst_m_key", {128'd0, m_key}, 256'd0);
      chk("rst_m2_key", m2_key, 256'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_s_ready", {255'd0, s_ready}, 256'd1);
      chk("post_rst_s2_ready", {255'd0, s2_ready}, 256'd1);

      // Plaintext before any key: dropped with an error pulse
      send_bytes({pt1, 128'd0}, 0, 15, 1'b0, 1'b0);
      chk("nokey_err_before_last", {255'd0, err}, 256'd0);
      send_bytes({pt1, 128'd0}, 15, 1, 1'b0, 1'b0);
      chk("nokey_err_pulse", {255'd0, err}, 256'd1);
      chk("nokey_m_valid", {255'd0, m_valid}, 256'd0);
      chk("nokey_key_loaded", {255'd0, key_loaded}, 256'd0);
      @(posedge clk); #1;
      chk("nokey_err_one_cycle", {255'd0, err}, 256'd0);
      chk("nokey_s_ready", {255'd0, s_ready}, 256'd1);

      // FIPS-197 key then plaintext
      send_bytes({key1, 128'd0}, 0, 16, 1'b1, 1'b0);
      chk("key1_loaded", {255'd0, key_loaded}, 256'd1);
      chk("key1_m_key", {128'd0, m_key}, {128'd0, key1});
      chk("key1_m_valid", {255'd0, m_valid}, 256'd0);
      chk("key1_err", {255'd0, err}, 256'd0);
      send_bytes({pt1, 128'd0}, 0, 15, 1'b0, 1'b0);
      chk("pt1_m_valid_early", {255'd0, m_valid}, 256'd0);
      send_bytes({pt1, 128'd0}, 15, 1, 1'b0, 1'b0);
      chk("pt1_m_valid", {255'd0, m_valid}, 256'd1);
      chk("pt1_s_ready", {255'd0, s_ready}, 256'd0);
      chk("pt1_m_block", {128'd0, m_block}, {128'd0, pt1});
      chk("pt1_m_key", {128'd0, m_key}, {128'd0, key1});
      @(posedge clk); #1;
      chk("pt1_m_valid_drop", {255'd0, m_valid}, 256'd0);
      chk("pt1_s_ready_back", {255'd0, s_ready}, 256'd1);

      // Type switch mid-group: 5 plaintext bytes then a new key
      send_bytes({128'h1122334455, 128'd0} << 88, 0, 5, 1'b0, 1'b0);
      chk("sw_no_err_yet", {255'd0, err}, 256'd0);
      send_bytes({key2, 128'd0}, 0, 1, 1'b1, 1'b0);
      chk("sw_err_pulse", {255'd0, err}, 256'd1);
      chk("sw_key_unchanged", {128'd0, m_key}, {128'd0, key1});
      send_bytes({key2, 128'd0}, 1, 1, 1'b1, 1'b0);
      chk("sw_err_one_cycle", {255'd0, err}, 256'd0);
      send_bytes({key2, 128'd0}, 2, 13, 1'b1, 1'b0);
      chk("sw_partial_key_kept_old", {128'd0, m_key}, {128'd0, key1});
      send_bytes({key2, 128'd0}, 15, 1, 1'b1, 1'b0);
      chk("sw_new_key", {128'd0, m_key}, {128'd0, key2});
      chk("sw_block_unchanged", {128'd0, m_block}, {128'd0, pt1});
      chk("sw_m_valid", {255'd0, m_valid}, 256'd0);
      chk("sw_key_loaded", {255'd0, key_loaded}, 256'd1);

      // Backpressure: hold m_ready low for 10 cycles, stream bytes ignored
      m_ready = 1'b0;
      send_bytes({pt2, 128'd0}, 0, 16, 1'b0, 1'b0);
      chk("bp_m_valid", {255'd0, m_valid}, 256'd1);
      chk("bp_m_block", {128'd0, m_block}, {128'd0, pt2});
      s_valid = 1'b1; s_is_key = 1'b1; s_data = 8'h99;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("bp_hold_m_valid", {255'd0, m_valid}, 256'd1);
         chk("bp_hold_s_ready", {255'd0, s_ready}, 256'd0);
         chk("bp_hold_m_block", {128'd0, m_block}, {128'd0, pt2});
         chk("bp_hold_m_key", {128'd0, m_key}, {128'd0, key2});
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_s_ready", {255'd0, s_ready}, 256'd1);
      chk("bp_release_m_valid", {255'd0, m_valid}, 256'd0);
      send_bytes({pt1, 128'd0}, 0, 16, 1'b0, 1'b0);
      chk("bp_next_m_valid", {255'd0, m_valid}, 256'd1);
      chk("bp_next_m_block", {128'd0, m_block}, {128'd0, pt1});
      chk("bp_next_m_key", {128'd0, m_key}, {128'd0, key2});
      chk("bp_next_err", {255'd0, err}, 256'd0);
      @(posedge clk); #1;

      // Reset mid-plaintext
      send_bytes({pt3, 128'd0}, 0, 8, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_m_block", {128'd0, m_block}, 256'd0);
      chk("mrst_m_key", {128'd0, m_key}, 256'd0);
      chk("mrst_key_loaded", {255'd0, key_loaded}, 256'd0);
      chk("mrst_s_ready", {255'd0, s_ready}, 256'd0);
      chk("mrst_m_valid", {255'd0, m_valid}, 256'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      chk("mrst_after_key_loaded", {255'd0, key_loaded}, 256'd0);
      chk("mrst_after_s_ready", {255'd0, s_ready}, 256'd1);
      send_bytes({pt3, 128'd0}, 0, 16, 1'b0, 1'b0);
      chk("mrst_block_err", {255'd0, err}, 256'd1);
      chk("mrst_block_m_valid", {255'd0, m_valid}, 256'd0);

      // N=256 key and two back-to-back blocks
      send_bytes(key256, 0, 31, 1'b1, 1'b1);
      chk("k256_not_loaded_31", {255'd0, kl2}, 256'd0);
      chk("k256_key_zero_31", m2_key, 256'd0);
      send_bytes(key256, 31, 1, 1'b1, 1'b1);
      chk("k256_loaded", {255'd0, kl2}, 256'd1);
      chk("k256_m_key", m2_key, key256);
      send_bytes({pt1, 128'd0}, 0, 16, 1'b0, 1'b1);
      chk("k256_a_m_valid", {255'd0, m2_valid}, 256'd1);
      chk("k256_a_m_block", {128'd0, m2_block}, {128'd0, pt1});
      chk("k256_a_m_key", m2_key, key256);
      @(posedge clk); #1;
      chk("k256_a_drop", {255'd0, m2_valid}, 256'd0);
      send_bytes({pt3, 128'd0}, 0, 16, 1'b0, 1'b1);
      chk("k256_b_m_valid", {255'd0, m2_valid}, 256'd1);
      chk("k256_b_m_block", {128'd0, m2_block}, {128'd0, pt3});
      chk("k256_b_m_key", m2_key, key256);
      chk("k256_b_err", {255'd0, err2}, 256'd0);
      @(posedge clk); #1;
      chk("k256_b_drop", {255'd0, m2_valid}, 256'd0);

      $display("CHECKS %0d ERRORS %0d", nchecks, nerrs);
      $finish;
   end

endmodule
